// File: rtl/asyalu_drv_pkg.sv
// Shared types and defaults for the synchronous driver of the dual-rail async ALU.
// Provides the handshake FSM state encoding and the watchdog counter sizing helper.
package asyalu_drv_pkg;

  localparam int OP_W_DEF   = 4;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RTZ,
    CLR,
    DONE
  } state_e;

  // Bits needed to hold a count from 0 up to and including 'cycles'.
  function automatic int tmo_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/asyalu_sync.sv
// Multi-flop synchroniser bringing a single asynchronous level into the clock domain.
// All stages clear to 0 on synchronous reset.
module asyalu_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // stage samples the value its neighbour held before the edge.
  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= {chain_q[STAGES-2:0], d};
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/asyalu_sync_driver.sv
// Clocked 4-phase handshake master for the dual-rail async ALU (start/ack, clr_n).
// Optional per-phase watchdog with ALU clear pulse is enabled by ASYALU_TIMEOUT_EN.
module asyalu_sync_driver
  import asyalu_drv_pkg::*;
#(
  parameter int OP_W           = OP_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CLR_CYCLES     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  input  logic [OP_W-1:0]   cmd_op_i,
  output logic              cmd_ready_o,
  output logic              alu_start_o,
  output logic [OP_W-1:0]   alu_op_o,
  output logic              alu_clr_n_o,
  input  logic              alu_ack_i,
  input  logic [DATA_W-1:0] alu_dout_i,
  input  logic              alu_flag_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_flag_o,
  output logic              res_err_o
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1 || CLR_CYCLES < 1) begin : g_bad_cfg
    $error("asyalu_sync_driver: SYNC_STAGES must be >= 2 and cycle limits >= 1");
  end

  state_e            state_q, state_d;
  logic              ack_s;
  logic              accept, capture;
  logic              start_q, clr_n_q, flag_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] data_q;

  asyalu_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (alu_ack_i),
    .q   (ack_s)
  );

  assign accept  = (state_q == IDLE) && cmd_valid_i;
  assign capture = (state_q == REQ) && ack_s;

`ifdef ASYALU_TIMEOUT_EN
  localparam int TMO_W = tmo_w(TIMEOUT_CYCLES);
  localparam int CLR_W = tmo_w(CLR_CYCLES);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic [CLR_W-1:0] clr_cnt_q;
  logic             tmo_hit, clr_done, err_q;

  assign tmo_hit  = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign clr_done = (clr_cnt_q == CLR_W'(CLR_CYCLES - 1));

  // Both counters restart on every state change, so each phase gets a full budget.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_d != state_q) begin
      tmo_cnt_q <= '0;
      clr_cnt_q <= '0;
    end else begin
      if (state_q == REQ || state_q == RTZ) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (state_q == CLR)                   clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                          err_q <= 1'b0;
    else if (capture)                   err_q <= 1'b0;
    else if (state_q == CLR && clr_done) err_q <= 1'b1;
  end

  assign res_err_o = err_q;
`else
  assign res_err_o = 1'b0;
`endif

  // NOTE: state_d gets its default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid_i) state_d = REQ;
      REQ: begin
        if (ack_s) state_d = RTZ;
`ifdef ASYALU_TIMEOUT_EN
        else if (tmo_hit) state_d = CLR;
`endif
      end
      RTZ: begin
        if (!ack_s) state_d = DONE;
`ifdef ASYALU_TIMEOUT_EN
        else if (tmo_hit) state_d = CLR;
`endif
      end
      CLR: begin
`ifdef ASYALU_TIMEOUT_EN
        if (clr_done) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // start and clr_n are registered from the next state so the ALU sees glitch-free levels.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      clr_n_q <= 1'b0;
      op_q    <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= (state_d == REQ);
      clr_n_q <= (state_d != CLR);
      if (accept) op_q <= cmd_op_i;
      if (capture) begin
        data_q <= alu_dout_i;
        flag_q <= alu_flag_i;
      end
`ifdef ASYALU_TIMEOUT_EN
      if (state_q == CLR && clr_done) begin
        data_q <= '0;
        flag_q <= 1'b0;
      end
`endif
    end
  end

  assign cmd_ready_o = (state_q == IDLE) && !rst_i;
  assign res_valid_o = (state_q == DONE);
  assign alu_start_o = start_q;
  assign alu_op_o    = op_q;
  assign alu_clr_n_o = clr_n_q;
  assign res_data_o  = data_q;
  assign res_flag_o  = flag_q;

endmodule
